mul_div_unit: RTL and testbench

Iterative unsigned multiply/divide unit sitting between the register file read ports and its write port. It consumes `ReadA`/`ReadB` as operands on a start pulse and computes one result bit per cycle. It then writes the result back through the register file's `RegWrite`/`writeReg`/`writeValue` port as a single-cycle write. This gives the core MUL/MULHU/DIVU/REMU without a combinational array multiplier or divider.

---
 rtl/mul_div_unit.sv | 195 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned MUL/MULHU/DIVU/REMU unit. It takes register
// file operands on a start pulse, produces one result bit per cycle, and ends
// with a single-cycle register file write-back.
module mul_div_unit #(
    parameter int W = 32,
    parameter int D = 5
) (
    input  logic         CLK,
    input  logic         ResetN,
    input  logic         Start,
    input  logic [1:0]   Op,
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    input  logic [D-1:0] destReg,
    output logic         Busy,
    output logic         Done,
    output logic         RegWrite,
    output logic [D-1:0] writeReg,
    output logic [W-1:0] writeValue
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [D-1:0]   dest_q, dest_d;
    // Multiply: {partial product high, multiplier/product low}.
    // Divide: low half holds dividend bits shifting out and quotient bits shifting in.
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   rem_q, rem_d;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           regwrite_q, regwrite_d;
    logic [D-1:0]   writereg_q, writereg_d;
    logic [W-1:0]   writevalue_q, writevalue_d;

    logic [W:0]     sum_s;
    logic [W:0]     shifted_s;
    logic [W:0]     diff_s;
    logic           div0_s;
    logic [W-1:0]   res_s;

    // State, datapath and registered-output flops with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!ResetN) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            dest_q       <= '0;
            acc_q        <= '0;
            rem_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            regwrite_q   <= 1'b0;
            writereg_q   <= '0;
            writevalue_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            dest_q       <= dest_d;
            acc_q        <= acc_d;
            rem_q        <= rem_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            regwrite_q   <= regwrite_d;
            writereg_q   <= writereg_d;
            writevalue_q <= writevalue_d;
        end
    end

    // Next-state and iteration counter; a divide by zero skips RUN entirely.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    cnt_d = '0;
                    if (Op[1] && (opB == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Operand capture plus one shift-add or restoring-divide step per RUN cycle.
    always_comb begin
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        dest_d = dest_q;
        acc_d  = acc_q;
        rem_d  = rem_q;

        sum_s     = {1'b0, acc_q[2*W-1:W]} + ({1'b0, a_q} & {(W+1){acc_q[0]}});
        shifted_s = {rem_q, acc_q[W-1]};
        diff_s    = shifted_s - {1'b0, b_q};

        if ((state_q == ST_IDLE) && Start) begin
            op_d   = Op;
            a_d    = opA;
            b_d    = opB;
            dest_d = destReg;
            rem_d  = '0;
            if (Op[1]) begin
                acc_d = {{W{1'b0}}, opA};
            end else begin
                acc_d = {{W{1'b0}}, opB};
            end
        end else if (state_q == ST_RUN) begin
            if (!op_q[1]) begin
                acc_d = {sum_s, acc_q[W-1:1]};
            end else if (!diff_s[W]) begin
                rem_d = diff_s[W-1:0];
                acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted_s[W-1:0];
                acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], 1'b0};
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Output values for the coming cycle; non-zero only while entering DONE.
    always_comb begin
        div0_s = op_d[1] && (b_d == '0);
        case (op_d)
            OP_MUL:   res_s = acc_d[W-1:0];
            OP_MULHU: res_s = acc_d[2*W-1:W];
            OP_DIVU:  res_s = div0_s ? {W{1'b1}} : acc_d[W-1:0];
            OP_REMU:  res_s = div0_s ? a_d : rem_d;
            default:  res_s = '0;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (done_d) begin
            regwrite_d   = (dest_d != '0);
            writereg_d   = dest_d;
            writevalue_d = res_s;
        end else begin
            regwrite_d   = 1'b0;
            writereg_d   = '0;
            writevalue_d = '0;
        end
    end

    assign Busy       = busy_q;
    assign Done       = done_q;
    assign RegWrite   = regwrite_q;
    assign writeReg   = writereg_q;
    assign writeValue = writevalue_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand-written
// corner sequences (Start during RUN, reset mid-RUN) and randomized ops
// compared against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int W = 32;
    localparam int D = 5;
    localparam int LAT_RUN  = W + 1;
    localparam int LAT_DIV0 = 1;

    logic         CLK = 1'b0;
    logic         ResetN;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic [D-1:0] destReg;
    logic         Busy;
    logic         Done;
    logic         RegWrite;
    logic [D-1:0] writeReg;
    logic [W-1:0] writeValue;

    int n_cmp = 0;
    int n_bad = 0;

    mul_div_unit #(.W(W), .D(D)) dut (
        .CLK        (CLK),
        .ResetN     (ResetN),
        .Start      (Start),
        .Op         (Op),
        .opA        (opA),
        .opB        (opB),
        .destReg    (destReg),
        .Busy       (Busy),
        .Done       (Done),
        .RegWrite   (RegWrite),
        .writeReg   (writeReg),
        .writeValue (writeValue)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic [31:0] expv;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Issue one op, count edges from the accept edge until Done, check write-back.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dest,
                         input logic [31:0] expv, input int explat, input bit poke);
        int edges;
        bit early_wr;
        @(negedge CLK);
        Start = 1'b1; Op = op; opA = a; opB = b; destReg = dest;
        @(posedge CLK);
        edges = 1;
        @(negedge CLK);
        Start = 1'b0; Op = 2'($urandom); opA = $urandom; opB = $urandom; destReg = 5'($urandom);
        chk({name, " busy_after_accept"}, 32'(Busy), 32'd1);
        early_wr = 1'b0;
        while (!Done && edges < 40) begin
            if (RegWrite) early_wr = 1'b1;
            Start = (poke && edges == 5) ? 1'b1 : 1'b0;
            @(posedge CLK);
            edges++;
            @(negedge CLK);
        end
        Start = 1'b0;
        chk({name, " done"}, 32'(Done), 32'd1);
        chk({name, " latency"}, 32'(edges), 32'(explat));
        chk({name, " early_write"}, 32'(early_wr), 32'd0);
        chk({name, " regwrite"}, 32'(RegWrite), (dest != 5'd0) ? 32'd1 : 32'd0);
        chk({name, " writereg"}, 32'(writeReg), 32'(dest));
        chk({name, " value"}, writeValue, expv);
        @(negedge CLK);
        chk({name, " done_pulse_end"}, 32'(Done), 32'd0);
        chk({name, " busy_end"}, 32'(Busy), 32'd0);
        chk({name, " regwrite_end"}, 32'(RegWrite), 32'd0);
        chk({name, " value_end"}, writeValue, 32'd0);
    endtask

    initial begin
        tbl[0] = '{"mul_x3",      2'd0, 32'h6789ABCD, 32'd3,        5'd1,  32'h369D0367, LAT_RUN};
        tbl[1] = '{"mulhu_x3",    2'd1, 32'h6789ABCD, 32'd3,        5'd1,  32'h00000001, LAT_RUN};
        tbl[2] = '{"mulhu_max",   2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, LAT_RUN};
        tbl[3] = '{"mul_max",     2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h00000001, LAT_RUN};
        tbl[4] = '{"divu_100_7",  2'd2, 32'd100,      32'd7,        5'd9,  32'h0000000E, LAT_RUN};
        tbl[5] = '{"remu_100_7",  2'd3, 32'd100,      32'd7,        5'd10, 32'h00000002, LAT_RUN};
        tbl[6] = '{"divu_msb_1",  2'd2, 32'h80000000, 32'd1,        5'd31, 32'h80000000, LAT_RUN};
        tbl[7] = '{"divu_by0",    2'd2, 32'h00001234, 32'd0,        5'd11, 32'hFFFFFFFF, LAT_DIV0};
        tbl[8] = '{"remu_by0",    2'd3, 32'h00001234, 32'd0,        5'd12, 32'h00001234, LAT_DIV0};
        tbl[9] = '{"mul_dest0",   2'd0, 32'd1000,     32'd1000,     5'd0,  32'd1000000,  LAT_RUN};

        ResetN = 1'b0; Start = 1'b0; Op = 2'd0; opA = 32'd0; opB = 32'd0; destReg = 5'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset regwrite", 32'(RegWrite), 32'd0);
        chk("reset writereg", 32'(writeReg), 32'd0);
        chk("reset writevalue", writeValue, 32'd0);
        ResetN = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dest,
                  tbl[i].expv, tbl[i].lat, 1'b0);
        end

        // New Start with different operands during RUN must not disturb the op.
        do_op("mul_start_in_run", 2'd0, 32'h6789ABCD, 32'd3, 5'd1, 32'h369D0367, LAT_RUN, 1'b1);
        do_op("remu_start_in_run", 2'd3, 32'd100, 32'd7, 5'd4, 32'd2, LAT_RUN, 1'b1);

        // Reset at RUN iteration 10 aborts the op with no write-back.
        begin
            bit seen;
            @(negedge CLK);
            Start = 1'b1; Op = 2'd0; opA = 32'h12345; opB = 32'h777; destReg = 5'd3;
            @(posedge CLK);
            @(negedge CLK);
            Start = 1'b0;
            repeat (10) @(negedge CLK);
            ResetN = 1'b0;
            @(posedge CLK);
            @(negedge CLK);
            ResetN = 1'b1;
            chk("abort busy", 32'(Busy), 32'd0);
            chk("abort done", 32'(Done), 32'd0);
            chk("abort writevalue", writeValue, 32'd0);
            seen = 1'b0;
            repeat (40) begin
                @(negedge CLK);
                if (Done || RegWrite || Busy) seen = 1'b1;
            end
            chk("abort no_writeback", 32'(seen), 32'd0);
        end
        do_op("after_reset_mul", 2'd0, 32'h12345, 32'h777, 5'd3, ref_model(2'd0, 32'h12345, 32'h777),
              LAT_RUN, 1'b0);

        // Randomized ops against the arithmetic reference model.
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [4:0]  rd;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            rd = 5'($urandom_range(0, 31));
            do_op($sformatf("rand%0d", k), rop, ra, rb, rd, ref_model(rop, ra, rb),
                  (rop[1] && rb == 32'd0) ? LAT_DIV0 : LAT_RUN, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
